// File: rtl/store_forward_queue_pkg.sv
// rtl/store_forward_queue_pkg.sv - shared store-queue types, default sizing and mask helper
package store_forward_queue_pkg;

  localparam int SQ_DEPTH = 16;
  localparam int SQ_IDX_W = $clog2(SQ_DEPTH);
  localparam int SQ_PTR_W = SQ_IDX_W + 1;

  // Position pointer: MSB is the wrap bit that separates full from empty.
  typedef logic [SQ_PTR_W-1:0] sq_ptr_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  mask;
    logic        addr_valid;
    logic        committed;
  } sq_entry_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  mask;
  } sq_ex_pkt_t;

  function automatic logic mask_covers(input logic [3:0] st_mask, input logic [3:0] ld_mask);
    return (st_mask & ld_mask) == ld_mask;
  endfunction

endpackage

// File: rtl/sq_forward_select.sv
// rtl/sq_forward_select.sv - youngest-first priority select of the store older than a load
module sq_forward_select
  import store_forward_queue_pkg::*;
#(
  parameter int DEPTH = SQ_DEPTH,
  localparam int IDX_W = $clog2(DEPTH),
  localparam int PTR_W = IDX_W + 1
) (
  input  sq_entry_t          entries_i [DEPTH],
  input  logic [PTR_W-1:0]   head_i,
  input  logic               ld_valid_i,
  input  logic [31:0]        ld_addr_i,
  input  logic [3:0]         ld_mask_i,
  input  logic [PTR_W-1:0]   ld_sq_pos_i,
  output logic               fwd_hit_o,
  output logic [31:0]        fwd_data_o,
  output logic               fwd_stall_o
);

  sq_entry_t        rot [DEPTH];
  logic [PTR_W-1:0] older_cnt;
  logic             found;
  logic             unused_byte_sel;

  assign unused_byte_sel = ^ld_addr_i[1:0];

  // rot[0] is the store just older than the load, rot[k] is k stores older still.
  always_comb begin
    older_cnt = ld_sq_pos_i - head_i;
    for (int k = 0; k < DEPTH; k++) begin
      rot[k] = entries_i[ld_sq_pos_i[IDX_W-1:0] - IDX_W'(k + 1)];
    end
  end

  always_comb begin
    fwd_hit_o   = 1'b0;
    fwd_stall_o = 1'b0;
    fwd_data_o  = '0;
    found       = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      if (!found && ld_valid_i && (PTR_W'(k) < older_cnt)) begin
        if (!rot[k].addr_valid) begin
          found       = 1'b1;
          fwd_stall_o = 1'b1;
        end else if ((rot[k].addr[31:2] == ld_addr_i[31:2]) && |(rot[k].mask & ld_mask_i)) begin
          found = 1'b1;
          if (mask_covers(rot[k].mask, ld_mask_i)) begin
            fwd_hit_o  = 1'b1;
            fwd_data_o = rot[k].data;
          end else begin
            fwd_stall_o = 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: rtl/store_forward_queue.sv
// rtl/store_forward_queue.sv - store queue with in-order drain; forwarding scan built only with SQ_STORE_FORWARD_EN
module store_forward_queue
  import store_forward_queue_pkg::*;
#(
  parameter int DEPTH      = SQ_DEPTH,
  parameter int DISPATCH_W = 3,
  parameter int EXEC_W     = 2,
  parameter int RETIRE_W   = 3,
  localparam int IDX_W  = $clog2(DEPTH),
  localparam int PTR_W  = IDX_W + 1,
  localparam int FREE_W = $clog2(DEPTH + 1),
  localparam int CNT_W  = $clog2(RETIRE_W + 1),
  localparam int DCNT_W = $clog2(DISPATCH_W + 1)
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic [DISPATCH_W-1:0]            disp_valid_i,
  output logic [DISPATCH_W-1:0][IDX_W-1:0] disp_idx_o,
  output logic [FREE_W-1:0]                free_slots_o,
  input  logic [EXEC_W-1:0]                ex_valid_i,
  input  logic [EXEC_W-1:0][IDX_W-1:0]     ex_idx_i,
  input  logic [EXEC_W-1:0][31:0]          ex_addr_i,
  input  logic [EXEC_W-1:0][31:0]          ex_data_i,
  input  logic [EXEC_W-1:0][3:0]           ex_mask_i,
  input  logic [CNT_W-1:0]                 commit_count_i,
  input  logic                             flush_i,
  output logic                             mem_req_valid_o,
  output logic [31:0]                      mem_req_addr_o,
  output logic [31:0]                      mem_req_data_o,
  output logic [3:0]                       mem_req_mask_o,
  input  logic                             mem_req_ready_i,
  input  logic                             ld_valid_i,
  input  logic [31:0]                      ld_addr_i,
  input  logic [3:0]                       ld_mask_i,
  input  logic [PTR_W-1:0]                 ld_sq_pos_i,
  output logic                             fwd_hit_o,
  output logic [31:0]                      fwd_data_o,
  output logic                             fwd_stall_o,
  output logic                             empty_o
);

  logic [PTR_W-1:0]      head_q, head_d;
  logic [PTR_W-1:0]      commit_q, commit_d;
  logic [PTR_W-1:0]      tail_q, tail_d;
  logic [FREE_W-1:0]     free_slots_q, free_slots_d;
  sq_entry_t             entries_q [DEPTH];
  sq_entry_t             entries_d [DEPTH];
  sq_ex_pkt_t            ex_pkt [EXEC_W];
  logic                  drain_fire;
  logic [FREE_W:0]       room;
  logic                  disp_open;
  logic [DISPATCH_W-1:0] disp_take;
  logic [DCNT_W-1:0]     disp_cnt;
  logic [PTR_W-1:0]      uncmt_cnt;
  logic [IDX_W-1:0]      flush_off;

  assign mem_req_valid_o = (head_q != commit_q);
  assign drain_fire      = mem_req_valid_o && mem_req_ready_i;
  assign mem_req_addr_o  = entries_q[head_q[IDX_W-1:0]].addr;
  assign mem_req_data_o  = entries_q[head_q[IDX_W-1:0]].data;
  assign mem_req_mask_o  = entries_q[head_q[IDX_W-1:0]].mask;
  assign empty_o         = (head_q == tail_q);
  assign free_slots_o    = free_slots_q;

  always_comb begin
    for (int i = 0; i < DISPATCH_W; i++) begin
      disp_idx_o[i] = tail_q[IDX_W-1:0] + IDX_W'(i);
    end
  end

  always_comb begin
    for (int e = 0; e < EXEC_W; e++) begin
      ex_pkt[e] = '{addr: ex_addr_i[e], data: ex_data_i[e], mask: ex_mask_i[e]};
    end
  end

  // The slot freed by a same-cycle drain is reusable, so a full queue can drain and allocate together.
  always_comb begin
    room      = {1'b0, free_slots_q} + {{FREE_W{1'b0}}, drain_fire};
    disp_open = !flush_i;
    disp_take = '0;
    disp_cnt  = '0;
    for (int i = 0; i < DISPATCH_W; i++) begin
      if (!disp_valid_i[i] || ((FREE_W + 1)'(i) >= room)) begin
        disp_open = 1'b0;
      end
      disp_take[i] = disp_open;
      disp_cnt     = disp_cnt + DCNT_W'(disp_take[i]);
    end
  end

  always_comb begin
    entries_d = entries_q;
    head_d    = head_q + PTR_W'(drain_fire);
    commit_d  = commit_q + PTR_W'(commit_count_i);
    tail_d    = tail_q;
    uncmt_cnt = '0;
    flush_off = '0;

    if (!flush_i) begin
      for (int e = 0; e < EXEC_W; e++) begin
        if (ex_valid_i[e]) begin
          entries_d[ex_idx_i[e]].addr       = ex_pkt[e].addr;
          entries_d[ex_idx_i[e]].data       = ex_pkt[e].data;
          entries_d[ex_idx_i[e]].mask       = ex_pkt[e].mask;
          entries_d[ex_idx_i[e]].addr_valid = 1'b1;
        end
      end
    end

    for (int j = 0; j < RETIRE_W; j++) begin
      if (CNT_W'(j) < commit_count_i) begin
        entries_d[commit_q[IDX_W-1:0] + IDX_W'(j)].committed = 1'b1;
      end
    end

    if (flush_i) begin
      tail_d    = commit_d;
      uncmt_cnt = tail_q - commit_d;
      for (int i = 0; i < DEPTH; i++) begin
        flush_off = IDX_W'(i) - commit_d[IDX_W-1:0];
        if ({1'b0, flush_off} < uncmt_cnt) begin
          entries_d[i] = '0;
        end
      end
    end else begin
      tail_d = tail_q + PTR_W'(disp_cnt);
      for (int i = 0; i < DISPATCH_W; i++) begin
        if (disp_take[i]) begin
          entries_d[disp_idx_o[i]] = '0;
        end
      end
    end

    free_slots_d = FREE_W'(DEPTH) - FREE_W'(tail_d - head_d);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      head_q       <= '0;
      commit_q     <= '0;
      tail_q       <= '0;
      free_slots_q <= FREE_W'(DEPTH);
      for (int i = 0; i < DEPTH; i++) begin
        entries_q[i] <= '0;
      end
    end else begin
      head_q       <= head_d;
      commit_q     <= commit_d;
      tail_q       <= tail_d;
      free_slots_q <= free_slots_d;
      entries_q    <= entries_d;
    end
  end

`ifdef SQ_STORE_FORWARD_EN
  sq_forward_select #(
    .DEPTH(DEPTH)
  ) u_forward_select (
    .entries_i   (entries_q),
    .head_i      (head_q),
    .ld_valid_i  (ld_valid_i),
    .ld_addr_i   (ld_addr_i),
    .ld_mask_i   (ld_mask_i),
    .ld_sq_pos_i (ld_sq_pos_i),
    .fwd_hit_o   (fwd_hit_o),
    .fwd_data_o  (fwd_data_o),
    .fwd_stall_o (fwd_stall_o)
  );
`else
  logic unused_ld_fields;
  assign unused_ld_fields = ^{ld_addr_i, ld_mask_i};
  // Without the scan, any older store still in the queue blocks the load.
  assign fwd_hit_o   = 1'b0;
  assign fwd_data_o  = '0;
  assign fwd_stall_o = ld_valid_i && (ld_sq_pos_i != head_q);
`endif

endmodule

// File: tb/tb_store_forward_queue.sv
// tb/tb_store_forward_queue.sv - scoreboard bench for store_forward_queue (SQ_STORE_FORWARD_EN aware)
module tb_store_forward_queue;

  localparam int DEPTH = 16;

  logic             clock = 1'b0;
  logic             reset;
  logic [2:0]       disp_valid_i;
  logic [2:0][3:0]  disp_idx_o;
  logic [4:0]       free_slots_o;
  logic [1:0]       ex_valid_i;
  logic [1:0][3:0]  ex_idx_i;
  logic [1:0][31:0] ex_addr_i;
  logic [1:0][31:0] ex_data_i;
  logic [1:0][3:0]  ex_mask_i;
  logic [1:0]       commit_count_i;
  logic             flush_i;
  logic             mem_req_valid_o;
  logic [31:0]      mem_req_addr_o;
  logic [31:0]      mem_req_data_o;
  logic [3:0]       mem_req_mask_o;
  logic             mem_req_ready_i;
  logic             ld_valid_i;
  logic [31:0]      ld_addr_i;
  logic [3:0]       ld_mask_i;
  logic [4:0]       ld_sq_pos_i;
  logic             fwd_hit_o;
  logic [31:0]      fwd_data_o;
  logic             fwd_stall_o;
  logic             empty_o;

  store_forward_queue dut (
    .clock(clock), .reset(reset),
    .disp_valid_i(disp_valid_i), .disp_idx_o(disp_idx_o), .free_slots_o(free_slots_o),
    .ex_valid_i(ex_valid_i), .ex_idx_i(ex_idx_i), .ex_addr_i(ex_addr_i),
    .ex_data_i(ex_data_i), .ex_mask_i(ex_mask_i),
    .commit_count_i(commit_count_i), .flush_i(flush_i),
    .mem_req_valid_o(mem_req_valid_o), .mem_req_addr_o(mem_req_addr_o),
    .mem_req_data_o(mem_req_data_o), .mem_req_mask_o(mem_req_mask_o),
    .mem_req_ready_i(mem_req_ready_i),
    .ld_valid_i(ld_valid_i), .ld_addr_i(ld_addr_i), .ld_mask_i(ld_mask_i),
    .ld_sq_pos_i(ld_sq_pos_i),
    .fwd_hit_o(fwd_hit_o), .fwd_data_o(fwd_data_o), .fwd_stall_o(fwd_stall_o),
    .empty_o(empty_o)
  );

  always #5 clock = ~clock;

  int          checks = 0;
  int          errors = 0;
  int          drains = 0;
  int          cptr   = 0;
  logic [67:0] exp_q[$];
  logic [31:0] m_addr [DEPTH];
  logic [31:0] m_data [DEPTH];
  logic [3:0]  m_mask [DEPTH];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    disp_valid_i = '0; ex_valid_i = '0; ex_idx_i = '0; ex_addr_i = '0; ex_data_i = '0;
    ex_mask_i = '0; commit_count_i = '0; flush_i = 1'b0; mem_req_ready_i = 1'b0;
    ld_valid_i = 1'b0; ld_addr_i = '0; ld_mask_i = '0; ld_sq_pos_i = '0;
    cyc();
    cyc();
    reset = 1'b0;
    exp_q.delete();
    drains = 0;
    cptr = 0;
  endtask

  task automatic dispatch(input int n);
    disp_valid_i = 3'((1 << n) - 1);
    cyc();
    disp_valid_i = '0;
  endtask

  // Stage an execute write on one port (no clock) and record it in the model.
  task automatic ex_set(input int p, input int idx, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] m);
    ex_valid_i[p] = 1'b1;
    ex_idx_i[p]   = 4'(idx);
    ex_addr_i[p]  = a;
    ex_data_i[p]  = d;
    ex_mask_i[p]  = m;
    m_addr[idx] = a;
    m_data[idx] = d;
    m_mask[idx] = m;
  endtask

  task automatic ex_go();
    cyc();
    ex_valid_i = '0;
  endtask

  task automatic commit(input int n);
    for (int j = 0; j < n; j++) begin
      exp_q.push_back({m_addr[(cptr + j) % DEPTH], m_data[(cptr + j) % DEPTH], m_mask[(cptr + j) % DEPTH]});
    end
    cptr = cptr + n;
    commit_count_i = 2'(n);
    cyc();
    commit_count_i = '0;
  endtask

  task automatic ld_check(input string name, input logic v, input logic [31:0] a,
                          input logic [3:0] m, input int pos,
                          input logic f_hit, input logic f_stall, input logic [31:0] f_data,
                          input logic n_stall);
    ld_valid_i = v; ld_addr_i = a; ld_mask_i = m; ld_sq_pos_i = 5'(pos);
    #1;
`ifdef SQ_STORE_FORWARD_EN
    check({name, "_hit"},   {31'b0, fwd_hit_o},   {31'b0, f_hit});
    check({name, "_stall"}, {31'b0, fwd_stall_o}, {31'b0, f_stall});
    check({name, "_data"},  fwd_data_o, f_hit ? f_data : fwd_data_o & 32'h0);
`else
    check({name, "_hit"},   {31'b0, fwd_hit_o},   32'h0);
    check({name, "_stall"}, {31'b0, fwd_stall_o}, {31'b0, n_stall});
    check({name, "_data"},  fwd_data_o, 32'h0);
`endif
    ld_valid_i = 1'b0;
  endtask

  // Scoreboard monitor: every accepted drain must match the oldest committed store.
  always @(negedge clock) begin
    logic [67:0] e;
    if (!reset && mem_req_valid_o && mem_req_ready_i) begin
      drains++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL drain_unexpected: got addr %h data %h, required no request", mem_req_addr_o, mem_req_data_o);
      end else begin
        e = exp_q.pop_front();
        if ({mem_req_addr_o, mem_req_data_o, mem_req_mask_o} !== e) begin
          errors++;
          $display("FAIL drain_data: got %h/%h/%h, required %h/%h/%h", mem_req_addr_o, mem_req_data_o,
                   mem_req_mask_o, e[67:36], e[35:4], e[3:0]);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time %0t, required completion", $time);
    $fatal(1);
  end

  initial begin
    do_reset();
    check("rst_free", 32'(free_slots_o), 32'd16);
    check("rst_empty", 32'(empty_o), 32'd1);
    check("rst_memv", 32'(mem_req_valid_o), 32'd0);
    check("rst_fwd", {30'b0, fwd_hit_o, fwd_stall_o}, 32'd0);

    // Three stores drain back to back in age order.
    check("disp_idx2", 32'(disp_idx_o[2]), 32'd2);
    dispatch(3);
    ex_set(0, 0, 32'h0000_1000, 32'h1111_0000, 4'hF);
    ex_set(1, 1, 32'h0000_1004, 32'h2222_0000, 4'h3);
    ex_go();
    ex_set(0, 2, 32'h0000_1008, 32'h3333_0000, 4'hC);
    ex_go();
    mem_req_ready_i = 1'b1;
    commit(3);
    repeat (3) cyc();
    mem_req_ready_i = 1'b0;
    check("t42_drains", 32'(drains), 32'd3);
    check("t42_empty", 32'(empty_o), 32'd1);
    check("t42_free", 32'(free_slots_o), 32'd16);
    check("t42_memv", 32'(mem_req_valid_o), 32'd0);

    // Fill to capacity, overflow lanes ignored, then drain+dispatch together.
    do_reset();
    repeat (5) dispatch(3);
    check("t43_free1", 32'(free_slots_o), 32'd1);
    check("t43_tail15", 32'(disp_idx_o[0]), 32'd15);
    dispatch(3);
    check("t43_free0", 32'(free_slots_o), 32'd0);
    check("t43_tail_wrap", 32'(disp_idx_o[0]), 32'd0);
    dispatch(1);
    check("t43_full_ign_free", 32'(free_slots_o), 32'd0);
    check("t43_full_ign_tail", 32'(disp_idx_o[0]), 32'd0);
    for (int i = 0; i < 8; i++) begin
      ex_set(0, 2 * i, 32'h4000 + 32'(2 * i) * 16, 32'hA500_0000 + 32'(2 * i), 4'hF);
      ex_set(1, 2 * i + 1, 32'h4000 + 32'(2 * i + 1) * 16, 32'hA500_0000 + 32'(2 * i + 1), 4'h1);
      ex_go();
    end
    repeat (5) commit(3);
    commit(1);
    check("t43_memv", 32'(mem_req_valid_o), 32'd1);
    mem_req_ready_i = 1'b1;
    disp_valid_i = 3'b001;
    cyc();
    disp_valid_i = '0;
    check("t43_swap_free", 32'(free_slots_o), 32'd0);
    check("t43_swap_tail", 32'(disp_idx_o[0]), 32'd1);
    repeat (15) cyc();
    mem_req_ready_i = 1'b0;
    check("t43_drains", 32'(drains), 32'd16);
    check("t43_free15", 32'(free_slots_o), 32'd15);
    check("t43_memv_end", 32'(mem_req_valid_o), 32'd0);
    check("t43_not_empty", 32'(empty_o), 32'd0);

    // Flush drops uncommitted entries while the stalled drain holds steady.
    do_reset();
    dispatch(3);
    dispatch(2);
    ex_set(0, 0, 32'h0000_2000, 32'h1111_1111, 4'hF);
    ex_set(1, 1, 32'h0000_2004, 32'h2222_2222, 4'h3);
    ex_go();
    commit(2);
    ex_set(0, 2, 32'h0000_2008, 32'h3333_3333, 4'hF);
    ex_go();
    flush_i = 1'b1;
    cyc();
    flush_i = 1'b0;
    check("t44_tail", 32'(disp_idx_o[0]), 32'd2);
    check("t44_free", 32'(free_slots_o), 32'd14);
    for (int k = 0; k < 3; k++) begin
      check("t44_hold_valid", 32'(mem_req_valid_o), 32'd1);
      check("t44_hold_addr", mem_req_addr_o, 32'h0000_2000);
      check("t44_hold_data", mem_req_data_o, 32'h1111_1111);
      cyc();
    end
    mem_req_ready_i = 1'b1;
    repeat (2) cyc();
    mem_req_ready_i = 1'b0;
    check("t44_drains", 32'(drains), 32'd2);
    check("t44_empty", 32'(empty_o), 32'd1);
    check("t44_free16", 32'(free_slots_o), 32'd16);

    // Forwarding queries.
    do_reset();
    dispatch(1);
    ex_set(0, 0, 32'h0000_0100, 32'hDEAD_BEEF, 4'hF);
    ex_go();
    ld_check("f_full_cover", 1'b1, 32'h102, 4'h4, 1, 1'b1, 1'b0, 32'hDEAD_BEEF, 1'b1);
    ld_check("f_pos_head", 1'b1, 32'h102, 4'h4, 0, 1'b0, 1'b0, 32'h0, 1'b0);
    ld_check("f_no_valid", 1'b0, 32'h102, 4'h4, 1, 1'b0, 1'b0, 32'h0, 1'b0);
    dispatch(1);
    ld_check("f_unknown_addr", 1'b1, 32'h102, 4'h4, 2, 1'b0, 1'b1, 32'h0, 1'b1);
    ex_set(0, 1, 32'h0000_0200, 32'h1122_3344, 4'h3);
    ex_go();
    ld_check("f_partial", 1'b1, 32'h200, 4'hF, 2, 1'b0, 1'b1, 32'h0, 1'b1);
    ld_check("f_sub_cover", 1'b1, 32'h201, 4'h1, 2, 1'b1, 1'b0, 32'h1122_3344, 1'b1);
    ld_check("f_no_overlap", 1'b1, 32'h200, 4'hC, 2, 1'b0, 1'b0, 32'h0, 1'b1);
    ld_check("f_no_match", 1'b1, 32'h300, 4'hF, 2, 1'b0, 1'b0, 32'h0, 1'b1);
    dispatch(1);
    ex_set(1, 2, 32'h0000_0100, 32'hCAFE_F00D, 4'hF);
    ex_go();
    ld_check("f_youngest", 1'b1, 32'h100, 4'hF, 3, 1'b1, 1'b0, 32'hCAFE_F00D, 1'b1);
    ld_check("f_older_only", 1'b1, 32'h100, 4'hF, 2, 1'b1, 1'b0, 32'hDEAD_BEEF, 1'b1);

    // Reset wins over a live drain handshake.
    do_reset();
    dispatch(1);
    ex_set(0, 0, 32'h0000_3000, 32'h5555_AAAA, 4'hF);
    ex_go();
    commit(1);
    reset = 1'b1;
    mem_req_ready_i = 1'b1;
    cyc();
    reset = 1'b0;
    mem_req_ready_i = 1'b0;
    exp_q.delete();
    check("rst_mid_memv", 32'(mem_req_valid_o), 32'd0);
    check("rst_mid_empty", 32'(empty_o), 32'd1);
    check("rst_mid_free", 32'(free_slots_o), 32'd16);
    check("rst_mid_tail", 32'(disp_idx_o[0]), 32'd0);
    check("rst_mid_drains", 32'(drains), 32'd0);

    check("sb_leftover", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
